// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for a 5-stage in-order core.
//
// Purpose:
//   Generates stage-register enables and clears for load-use stalls, taken-branch
//   flushes and data-memory wait stalls. It also raises a sticky fault when the data
//   memory does not answer within MEM_TIMEOUT wait cycles. EX operand forwarding
//   selects are produced independently of the control state. A saturating counter
//   tracks the number of cycles in which the PC was held.
//
// Ports:
//   clk, clr                     clock, synchronous active-high reset
//   id_rs1, id_rs2               ID-stage source registers
//   ex_rs1, ex_rs2, ex_rd        EX-stage sources and destination
//   ex_mem_read                  EX instruction is a load
//   mem_rd, mem_reg_write        MEM-stage destination and write enable
//   wb_rd, wb_reg_write          WB-stage destination and write enable
//   branch_taken                 EX resolved a taken branch/jump
//   mem_req, mem_ready           MEM-stage access pending, data memory done
//   pc_en .. exmem_en            stage-register enables
//   ifid_clr .. memwb_clr        stage-register clears
//   fwd_a, fwd_b                 EX operand mux selects (10 MEM, 01 WB, 00 regfile)
//   mem_fault                    sticky data-memory timeout flag
//   stall_cycles                 saturating count of cycles with pc_en=0
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  ex_rs1,
    input  logic [4:0]  ex_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic [4:0]  mem_rd,
    input  logic        mem_reg_write,
    input  logic [4:0]  wb_rd,
    input  logic        wb_reg_write,
    input  logic        branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        ifid_clr,
    output logic        idex_clr,
    output logic        exmem_clr,
    output logic        memwb_clr,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        mem_fault,
    output logic [15:0] stall_cycles
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_FAULT    = 2'd2;

    localparam logic [7:0] LP_TIMEOUT  = 8'(MEM_TIMEOUT);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [1:0]  w_state_eff;
    logic [7:0]  r_wait_cnt;
    logic [7:0]  w_wait_cnt_nxt;
    logic [7:0]  w_wait_inc;
    logic [15:0] r_stall_cnt;
    logic        w_mem_miss;
    logic        w_load_use;

    assign w_mem_miss = mem_req & ~mem_ready;
    assign w_load_use = ex_mem_read && (ex_rd != 5'd0) &&
                        ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    assign w_wait_inc = r_wait_cnt + 8'd1;

    // While clr is held the controls already look like RUN, so the pipeline
    // sees defaults (plus any live hazard) in the reset cycle itself.
    assign w_state_eff = clr ? ST_RUN : r_state;

    // Stage controls: FAULT > memory stall > branch flush > load-use.
    always_comb begin
        pc_en     = 1'b1;
        ifid_en   = 1'b1;
        idex_en   = 1'b1;
        exmem_en  = 1'b1;
        ifid_clr  = 1'b0;
        idex_clr  = 1'b0;
        exmem_clr = 1'b0;
        memwb_clr = 1'b0;
        case (w_state_eff)
            ST_RUN: begin
                if (w_mem_miss) begin
                    pc_en     = 1'b0;
                    ifid_en   = 1'b0;
                    idex_en   = 1'b0;
                    exmem_en  = 1'b0;
                    memwb_clr = 1'b1;
                end else if (branch_taken) begin
                    ifid_clr = 1'b1;
                    idex_clr = 1'b1;
                end else if (w_load_use) begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    idex_clr = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                pc_en     = 1'b0;
                ifid_en   = 1'b0;
                idex_en   = 1'b0;
                exmem_en  = 1'b0;
                // On the ready cycle the load result is let into MEM/WB.
                memwb_clr = ~mem_ready;
            end
            default: begin
                pc_en     = 1'b0;
                ifid_en   = 1'b0;
                idex_en   = 1'b0;
                exmem_en  = 1'b0;
                ifid_clr  = 1'b1;
                idex_clr  = 1'b1;
                exmem_clr = 1'b1;
                memwb_clr = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        case (r_state)
            ST_RUN: begin
                if (w_mem_miss) begin
                    w_state_nxt    = ST_MEM_WAIT;
                    w_wait_cnt_nxt = 8'd0;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_wait_cnt_nxt = w_wait_inc;
                    if (w_wait_inc == LP_TIMEOUT) begin
                        w_state_nxt = ST_FAULT;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_FAULT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state     <= ST_RUN;
            r_wait_cnt  <= 8'd0;
            r_stall_cnt <= 16'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (!pc_en && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign mem_fault    = (r_state == ST_FAULT);
    assign stall_cycles = r_stall_cnt;

    // Forwarding: the younger producer (MEM) wins over WB; x0 never forwards.
    always_comb begin
        fwd_a = 2'b00;
        if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ex_rs1)) begin
            fwd_a = 2'b10;
        end else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_rs1)) begin
            fwd_a = 2'b01;
        end
        fwd_b = 2'b00;
        if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ex_rs2)) begin
            fwd_b = 2'b10;
        end else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_rs2)) begin
            fwd_b = 2'b01;
        end
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, max MEM_WAIT cycles before fault (1..255).
REQ-002 SHALL have ports (name direction width meaning):
- clk  in  1  clock
- clr  in  1  reset, synchronous, active-high
- id_rs1, id_rs2  in  5 each  ID-stage source registers
- ex_rs1, ex_rs2  in  5 each  EX-stage source registers
- ex_rd  in  5  EX-stage destination
- ex_mem_read  in  1  EX instruction is a load
- mem_rd, mem_reg_write  in  5 / 1  MEM-stage destination, write enable
- wb_rd, wb_reg_write  in  5 / 1  WB-stage destination, write enable
- branch_taken  in  1  EX resolved taken branch/jump
- mem_req, mem_ready  in  1 / 1  MEM-stage data access pending, data memory done
- pc_en, ifid_en, idex_en, exmem_en  out  1 each  stage-register enables
- ifid_clr, idex_clr, exmem_clr, memwb_clr  out  1 each  stage-register clears
- fwd_a, fwd_b  out  2 each  EX operand mux select
- mem_fault  out  1  sticky data-memory timeout flag
- stall_cycles  out  16  saturating stall-cycle count

Function
REQ-003 SHALL implement registered FSM states RUN, MEM_WAIT, FAULT; stage controls combinational from state and inputs.
REQ-004 Default (RUN, no hazard): all enables 1, all clears 0.
REQ-005 RUN -> MEM_WAIT when mem_req=1 and mem_ready=0; in that cycle and every MEM_WAIT cycle: pc_en=ifid_en=idex_en=exmem_en=0, memwb_clr=1, other clears 0.
REQ-006 MEM_WAIT -> RUN in the cycle after mem_ready=1 is sampled; the mem_ready=1 cycle itself still drives REQ-005 outputs except exmem_en=0 and memwb_clr=0 (MEM result captured into MEM/WB).
REQ-007 Wait counter (8-bit) SHALL clear on MEM_WAIT entry, increment each MEM_WAIT cycle with mem_ready=0; reaching MEM_TIMEOUT -> FAULT.
REQ-008 FAULT: all enables 0, all clears 1, mem_fault=1; exit only via clr.
REQ-009 In RUN with no memory stall, branch_taken=1 SHALL drive ifid_clr=1, idex_clr=1 for that cycle; pc_en=1.
REQ-010 Load-use: in RUN, no memory stall, branch_taken=0, ex_mem_read=1, ex_rd!=0, ex_rd equal to id_rs1 or id_rs2 -> pc_en=0, ifid_en=0, idex_clr=1, one cycle.
REQ-011 Priority: FAULT > memory stall > branch flush > load-use; branch_taken during stall is ignored (EX held, reasserted after release).
REQ-012 fwd_a: 2'b10 if mem_reg_write and mem_rd!=0 and mem_rd==ex_rs1; else 2'b01 if wb_reg_write and wb_rd!=0 and wb_rd==ex_rs1; else 2'b00. fwd_b identical on ex_rs2. Forwarding independent of FSM state.
REQ-013 stall_cycles SHALL increment on each cycle with pc_en=0, saturate at 16'hFFFF.
REQ-014 mem_req asserted with mem_ready=1 in RUN SHALL cause no stall.

Reset
REQ-015 clr=1 at a clock edge SHALL set state RUN, wait counter 0, mem_fault 0, stall_cycles 0, regardless of current state, including mid-MEM_WAIT and FAULT.
REQ-016 While clr=1 and in the first cycle after, outputs SHALL be RUN defaults (REQ-004) unless inputs create a hazard.

Verification
REQ-017 Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5 -> one cycle pc_en=0, ifid_en=0, idex_clr=1; stall_cycles 0->1.
REQ-018 Branch: branch_taken=1 in RUN -> ifid_clr=idex_clr=1, pc_en=1, stall_cycles unchanged.
REQ-019 Memory wait: mem_req=1, mem_ready=0 for 3 cycles then 1 -> 4 cycles pc_en=0, memwb_clr=1 for first 3, exmem_en=0 all 4, RUN next; stall_cycles=4.
REQ-020 Timeout: MEM_TIMEOUT=4, mem_ready held 0 -> FAULT after 4 MEM_WAIT cycles, mem_fault=1 sticky; clr -> mem_fault=0, RUN.
REQ-021 Forwarding: mem_rd=wb_rd=7, both write, ex_rs1=7 -> fwd_a=2'b10; mem_rd=0, wb_rd=0, ex_rs1=0 -> fwd_a=2'b00.
REQ-022 Simultaneous: mem stall plus branch_taken plus load-use -> REQ-005 outputs only, ifid_clr=0.
